// File: rtl/cache_fill_if.sv
// cache_fill_if: bundles the CPU miss check, the RAM burst port and the cache
// line-store port of the line-fill controller.
// Ports: cpu_strobe/cpu_addr/hit/flush (CPU side), ram_req/ram_addr/ram_ack/
//   ram_valid/ram_din (RAM arbiter), cache_addr/din64/store/store_ack (cache),
//   busy/fill_err (status). master = controller view, slave = environment view.
interface cache_fill_if;
  logic        cpu_strobe;
  logic [22:0] cpu_addr;
  logic        hit;
  logic        flush;
  logic        ram_req;
  logic [22:0] ram_addr;
  logic        ram_ack;
  logic        ram_valid;
  logic [15:0] ram_din;
  logic [22:0] cache_addr;
  logic [63:0] din64;
  logic        store;
  logic        store_ack;
  logic        busy;
  logic        fill_err;

  modport master (
    input  cpu_strobe, cpu_addr, hit, flush,
    input  ram_ack, ram_valid, ram_din, store_ack,
    output ram_req, ram_addr, cache_addr, din64, store, busy, fill_err
  );

  modport slave (
    output cpu_strobe, cpu_addr, hit, flush,
    output ram_ack, ram_valid, ram_din, store_ack,
    input  ram_req, ram_addr, cache_addr, din64, store, busy, fill_err
  );
endinterface

// File: rtl/cache_fill.sv
// Purpose: on a CPU read miss, fetch the aligned 4-word line as a 16-bit burst and hand it to the cache.
// Latency: miss->ram_req 1 cycle, last word->store 1 cycle, store_ack->store low 1 cycle, 2-cycle guard after.
// Backpressure: ram_req held until ram_ack, store held until store_ack; bounded by TIMEOUT, abortable by flush.
// Ports: clk_128 (clock), reset_n (async active-low), bus (cache_fill_if.master: CPU miss
//   inputs, RAM burst request/data, cache line store, busy/fill_err status).
module cache_fill #(
  parameter int TIMEOUT = 255
) (
  input logic          clk_128,
  input logic          reset_n,
  cache_fill_if.master bus
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    BURST = 3'd2,
    STORE = 3'd3,
    GUARD = 3'd4
  } state_t;

  state_t      state;
  logic [1:0]  cnt;        // next burst word slot
  logic        guard_cnt;  // second guard cycle
  logic [TW-1:0] tmo;      // cycles spent in REQ/BURST for this fill
  logic [22:0] line_addr;
  logic [63:0] line_dat;
  logic        ram_req_r;
  logic        store_r;
  logic        busy_r;
  logic        fill_err_r;

  // Word addressing within the line comes from the burst counter, not the CPU.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^bus.cpu_addr[1:0];

  // The tmo compare is taken from the current count, so the abort lands
  // exactly TIMEOUT cycles after ram_req rose.
  logic expired;
  logic last_word;
  assign expired   = (tmo == TMO_LAST);
  assign last_word = bus.ram_valid && (cnt == 2'd3);

  assign bus.ram_req    = ram_req_r;
  assign bus.ram_addr   = line_addr;
  assign bus.cache_addr = line_addr;
  assign bus.din64      = line_dat;
  assign bus.store      = store_r;
  assign bus.busy       = busy_r;
  assign bus.fill_err   = fill_err_r;

  always_ff @(posedge clk_128 or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= 2'd0;
      guard_cnt  <= 1'b0;
      tmo        <= '0;
      line_addr  <= 23'd0;
      line_dat   <= 64'd0;
      ram_req_r  <= 1'b0;
      store_r    <= 1'b0;
      busy_r     <= 1'b0;
      fill_err_r <= 1'b0;
    end else begin
      fill_err_r <= 1'b0;
      case (state)
        IDLE: begin
          // ram_valid stragglers after a flush land here and are dropped.
          if (bus.cpu_strobe && !bus.hit) begin
            line_addr <= {bus.cpu_addr[22:2], 2'b00};
            cnt       <= 2'd0;
            tmo       <= '0;
            ram_req_r <= 1'b1;
            busy_r    <= 1'b1;
            state     <= REQ;
          end
        end

        REQ: begin
          // ram_valid is ignored here, including in the ram_ack cycle.
          if (bus.flush) begin
            ram_req_r <= 1'b0;
            busy_r    <= 1'b0;
            state     <= IDLE;
          end else if (expired) begin
            ram_req_r  <= 1'b0;
            busy_r     <= 1'b0;
            fill_err_r <= 1'b1;
            state      <= IDLE;
          end else begin
            tmo <= tmo + 1'b1;
            if (bus.ram_ack) begin
              ram_req_r <= 1'b0;
              state     <= BURST;
            end
          end
        end

        BURST: begin
          if (bus.flush) begin
            busy_r <= 1'b0;
            state  <= IDLE;
          end else if (last_word) begin
            // The 4th word beats a coincident timeout.
            line_dat[{cnt, 4'b0000} +: 16] <= bus.ram_din;
            cnt     <= 2'd0;
            store_r <= 1'b1;
            state   <= STORE;
          end else if (expired) begin
            busy_r     <= 1'b0;
            fill_err_r <= 1'b1;
            state      <= IDLE;
          end else begin
            tmo <= tmo + 1'b1;
            if (bus.ram_valid) begin
              line_dat[{cnt, 4'b0000} +: 16] <= bus.ram_din;
              cnt <= cnt + 2'd1;
            end
          end
        end

        STORE: begin
          // A flush alongside store_ack still lets the cache take the line,
          // but skips the guard and returns straight to IDLE.
          if (bus.flush) begin
            store_r <= 1'b0;
            busy_r  <= 1'b0;
            state   <= IDLE;
          end else if (bus.store_ack) begin
            store_r   <= 1'b0;
            guard_cnt <= 1'b0;
            state     <= GUARD;
          end
        end

        GUARD: begin
          // Gives the cache's registered tag compare time to reflect the new
          // line before the next miss check.
          if (guard_cnt) begin
            guard_cnt <= 1'b0;
            busy_r    <= 1'b0;
            state     <= IDLE;
          end else begin
            guard_cnt <= 1'b1;
          end
        end

        default: begin
          ram_req_r <= 1'b0;
          store_r   <= 1'b0;
          busy_r    <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
